pre_if_stage: RTL and testbench

Pre-IF stage of the five-stage LoongArch pipeline, directly upstream of the IF stage. It owns the fetch PC and selects the next fetch address from sequential, branch, exception and ERTN sources. It issues instruction requests over an SRAM-like req/addr_ok handshake and buffers redirects that arrive while a request is in flight. It hands each accepted address to IF with a cancel flag, so IF can drop data belonging to stale requests.

---
 rtl/pre_if_stage.sv | 209 ++++++++++++++++++++
 tb/tb_pre_if_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pre_if_stage.sv
// ---------------------------------------------------------------------------
// pre_if_stage
//
// Pre-IF stage of the five-stage LoongArch pipeline. Owns the fetch PC,
// picks the next fetch address (sequential, branch, exception, ERTN),
// issues instruction requests on an SRAM-like req/addr_ok handshake and
// hands every accepted address to IF together with a cancel flag.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   fs_allowin            IF can accept a new fetch (sampled at request start)
//   br_taken/br_target    branch redirect from ID (one-cycle pulse)
//   wb_ex/eentry          exception flush from WB (one-cycle pulse)
//   ertn_flush/era        ERTN flush from WB (one-cycle pulse)
//   inst_sram_*           instruction SRAM request channel (read only)
//   ps_to_fs_valid/pc     fetch handed to IF this cycle
//   ps_to_fs_adef         misaligned PC, no bus request was made
//   ps_to_fs_cancel       IF must discard the returning instruction
// ---------------------------------------------------------------------------
module pre_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1C000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        wb_ex,
    input  logic [31:0] eentry,
    input  logic        ertn_flush,
    input  logic [31:0] era,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    output logic        ps_to_fs_valid,
    output logic [31:0] ps_to_fs_pc,
    output logic        ps_to_fs_adef,
    output logic        ps_to_fs_cancel
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;          // last non-cancelled issued PC
    logic [31:0] req_addr_r;    // address currently presented on the bus
    logic        req_r;
    logic        stale_r;       // in-flight request has been overtaken by a redirect
    logic        rd_valid_r;    // redirect buffer
    logic [31:0] rd_target_r;

    logic        live_redir_s;
    logic [31:0] live_target_s;
    logic        handshake_s;
    logic        cancel_s;
    logic [31:0] base_pc_s;
    logic [31:0] next_pc_s;
    logic        next_aligned_s;

    // Live redirect selection: ERTN beats exception beats branch.
    always_comb begin
        live_redir_s = ertn_flush | wb_ex | br_taken;
        if (ertn_flush) begin
            live_target_s = era;
        end else if (wb_ex) begin
            live_target_s = eentry;
        end else if (br_taken) begin
            live_target_s = br_target;
        end else begin
            live_target_s = 32'h0000_0000;
        end
    end

    assign handshake_s = (state_r == REQ) && inst_sram_addr_ok;
    assign cancel_s    = stale_r | live_redir_s;

    // Next fetch address. In a non-cancelled handshake cycle pc_r is being
    // overwritten with req_addr_r, so the sequential successor must be
    // computed from req_addr_r to allow back-to-back issue.
    always_comb begin
        if (handshake_s && !cancel_s) begin
            base_pc_s = req_addr_r;
        end else begin
            base_pc_s = pc_r;
        end
        if (live_redir_s) begin
            next_pc_s = live_target_s;
        end else if (rd_valid_r) begin
            next_pc_s = rd_target_r;
        end else begin
            next_pc_s = base_pc_s + 32'd4;
        end
    end

    assign next_aligned_s = (next_pc_s[1:0] == 2'b00);

    // Hand-off to IF: accepted bus address, or a misaligned PC reported
    // directly from IDLE without touching the bus.
    always_comb begin
        ps_to_fs_valid  = 1'b0;
        ps_to_fs_pc     = 32'h0000_0000;
        ps_to_fs_adef   = 1'b0;
        ps_to_fs_cancel = 1'b0;
        if (reset) begin
            ps_to_fs_valid = 1'b0;
        end else if (handshake_s) begin
            ps_to_fs_valid  = 1'b1;
            ps_to_fs_pc     = req_addr_r;
            ps_to_fs_cancel = cancel_s;
        end else if ((state_r == IDLE) && fs_allowin && !next_aligned_s) begin
            ps_to_fs_valid = 1'b1;
            ps_to_fs_pc    = next_pc_s;
            ps_to_fs_adef  = 1'b1;
        end else begin
            ps_to_fs_valid = 1'b0;
        end
    end

    assign inst_sram_req   = req_r;
    assign inst_sram_addr  = req_addr_r;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0000_0000;

    // Fetch state machine, PC, redirect buffer and registered request outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            pc_r        <= RESET_PC - 32'd4;
            req_addr_r  <= 32'h0000_0000;
            req_r       <= 1'b0;
            stale_r     <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_target_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fs_allowin) begin
                        rd_valid_r <= 1'b0;
                        if (next_aligned_s) begin
                            req_addr_r <= next_pc_s;
                            req_r      <= 1'b1;
                            stale_r    <= 1'b0;
                            state_r    <= REQ;
                        end else begin
                            state_r    <= HALT;
                        end
                    end else if (live_redir_s) begin
                        rd_valid_r  <= 1'b1;
                        rd_target_r <= live_target_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (inst_sram_addr_ok) begin
                        if (!cancel_s) begin
                            pc_r <= req_addr_r;
                        end
                        if (fs_allowin && next_aligned_s) begin
                            // Back-to-back issue consumes next (and any redirect).
                            req_addr_r <= next_pc_s;
                            stale_r    <= 1'b0;
                            rd_valid_r <= 1'b0;
                        end else begin
                            // Dropping to IDLE: a live redirect must survive there.
                            state_r <= IDLE;
                            req_r   <= 1'b0;
                            stale_r <= 1'b0;
                            if (live_redir_s) begin
                                rd_valid_r  <= 1'b1;
                                rd_target_r <= live_target_s;
                            end
                        end
                    end else if (live_redir_s) begin
                        stale_r     <= 1'b1;
                        rd_valid_r  <= 1'b1;
                        rd_target_r <= live_target_s;
                    end else begin
                        state_r <= REQ;
                    end
                end
                HALT: begin
                    if (live_redir_s) begin
                        rd_valid_r  <= 1'b1;
                        rd_target_r <= live_target_s;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= HALT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                    stale_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pre_if_stage.sv
module tb_pre_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        wb_ex;
    logic [31:0] eentry;
    logic        ertn_flush;
    logic [31:0] era;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        ps_to_fs_valid;
    logic [31:0] ps_to_fs_pc;
    logic        ps_to_fs_adef;
    logic        ps_to_fs_cancel;

    int checks = 0;
    int errors = 0;

    // expected hand-offs to IF: {adef, cancel, pc}
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    pre_if_stage #(.RESET_PC(32'h1C000000)) dut (
        .clk               (clk),
        .reset             (reset),
        .fs_allowin        (fs_allowin),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .wb_ex             (wb_ex),
        .eentry            (eentry),
        .ertn_flush        (ertn_flush),
        .era               (era),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .ps_to_fs_valid    (ps_to_fs_valid),
        .ps_to_fs_pc       (ps_to_fs_pc),
        .ps_to_fs_adef     (ps_to_fs_adef),
        .ps_to_fs_cancel   (ps_to_fs_cancel)
    );

    // Scoreboard consumer: every hand-off to IF is matched against the queue.
    always @(negedge clk) begin
        if (!reset && ps_to_fs_valid) begin
            logic [33:0] got;
            logic [33:0] exp;
            got = {ps_to_fs_adef, ps_to_fs_cancel, ps_to_fs_pc};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL handoff_unexpected: got adef=%0b cancel=%0b pc=%h, expected none",
                         got[33], got[32], got[31:0]);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL handoff: got adef=%0b cancel=%0b pc=%h, expected adef=%0b cancel=%0b pc=%h",
                             got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; fs_allowin = 1'b1; inst_sram_addr_ok = 1'b0;
        br_taken = 1'b0; br_target = 32'h0; wb_ex = 1'b0; eentry = 32'h0;
        ertn_flush = 1'b0; era = 32'h0;
        repeat (3) cyc();
        reset = 1'b0;
        sample();
        checks++;
        if ({inst_sram_req, ps_to_fs_valid, ps_to_fs_adef, ps_to_fs_cancel} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got req/valid/adef/cancel=%b, expected 0000",
                     {inst_sram_req, ps_to_fs_valid, ps_to_fs_adef, ps_to_fs_cancel});
        end
        checks++;
        if (inst_sram_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h, expected 00000000", inst_sram_addr);
        end
        checks++;
        if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'b10, 4'b0000, 32'h0}) begin
            errors++;
            $display("FAIL const_outputs: got wr=%b size=%b wstrb=%b wdata=%h, expected 0/10/0000/0",
                     inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr;
        for (int i = 0; i < 3; i++) begin
            exp_addr = 32'h1C000000 + 32'(i * 4);
            cyc();
            inst_sram_addr_ok = 1'b1;
            exp_q.push_back({1'b0, 1'b0, exp_addr});
            sample();
            checks++;
            if (inst_sram_req !== 1'b1 || inst_sram_addr !== exp_addr) begin
                errors++;
                $display("FAIL b2b_req[%0d]: got req=%b addr=%h, expected req=1 addr=%h",
                         i, inst_sram_req, inst_sram_addr, exp_addr);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d pending hand-offs, expected 0", exp_q.size());
        end
    endtask

    task automatic test_stall_redirect();
        // Bus stalls on 1C00000C for three cycles while a branch arrives.
        for (int i = 0; i < 3; i++) begin
            cyc();
            inst_sram_addr_ok = 1'b0;
            br_taken  = (i == 0);
            br_target = 32'h1C000100;
            sample();
            checks++;
            if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C00000C) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got req=%b addr=%h, expected req=1 addr=1c00000c",
                         i, inst_sram_req, inst_sram_addr);
            end
        end
        cyc();
        br_taken = 1'b0;
        inst_sram_addr_ok = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 32'h1C00000C});
        sample();
        cyc();
        exp_q.push_back({1'b0, 1'b0, 32'h1C000100});
        sample();
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C000100) begin
            errors++;
            $display("FAIL stall_target: got req=%b addr=%h, expected req=1 addr=1c000100",
                     inst_sram_req, inst_sram_addr);
        end
    endtask

    task automatic test_priority();
        cyc();
        inst_sram_addr_ok = 1'b1;
        br_taken = 1'b1; br_target = 32'h1C000200;
        wb_ex = 1'b1; eentry = 32'h1C008000;
        exp_q.push_back({1'b0, 1'b1, 32'h1C000104});
        sample();
        cyc();
        br_taken = 1'b0; wb_ex = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 32'h1C008000});
        sample();
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C008000) begin
            errors++;
            $display("FAIL prio_target: got req=%b addr=%h, expected req=1 addr=1c008000",
                     inst_sram_req, inst_sram_addr);
        end
    endtask

    task automatic test_misaligned();
        // Finish 1C008004 with IF blocked to fall back to IDLE.
        cyc();
        inst_sram_addr_ok = 1'b1; fs_allowin = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 32'h1C008004});
        sample();
        cyc();
        inst_sram_addr_ok = 1'b0; fs_allowin = 1'b1;
        br_taken = 1'b1; br_target = 32'h1C000102;
        exp_q.push_back({1'b1, 1'b0, 32'h1C000102});
        sample();
        checks++;
        if (inst_sram_req !== 1'b0) begin
            errors++;
            $display("FAIL adef_noreq: got req=%b, expected 0", inst_sram_req);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            br_taken = 1'b0;
            wb_ex  = (i == 3);
            eentry = 32'h1C008000;
            sample();
            checks++;
            if (inst_sram_req !== 1'b0) begin
                errors++;
                $display("FAIL halt_noreq[%0d]: got req=%b, expected 0", i, inst_sram_req);
            end
        end
        cyc();
        wb_ex = 1'b0;
        inst_sram_addr_ok = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 32'h1C008000});
        sample();
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C008000) begin
            errors++;
            $display("FAIL halt_exit: got req=%b addr=%h, expected req=1 addr=1c008000",
                     inst_sram_req, inst_sram_addr);
        end
    endtask

    task automatic test_allowin_low();
        cyc();
        inst_sram_addr_ok = 1'b1; fs_allowin = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 32'h1C008004});
        sample();
        for (int i = 0; i < 4; i++) begin
            cyc();
            inst_sram_addr_ok = 1'b0;
            ertn_flush = (i == 1);
            era = 32'h1C000050;
            sample();
            checks++;
            if (inst_sram_req !== 1'b0) begin
                errors++;
                $display("FAIL allowin_noreq[%0d]: got req=%b, expected 0", i, inst_sram_req);
            end
        end
        cyc();
        fs_allowin = 1'b1;
        sample();
        cyc();
        sample();
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C000050) begin
            errors++;
            $display("FAIL allowin_ertn: got req=%b addr=%h, expected req=1 addr=1c000050",
                     inst_sram_req, inst_sram_addr);
        end
    endtask

    task automatic test_reset_mid_req();
        cyc();
        reset = 1'b1;
        cyc();
        checks++;
        if (inst_sram_req !== 1'b0 || inst_sram_addr !== 32'h0) begin
            errors++;
            $display("FAIL midreset_drop: got req=%b addr=%h, expected req=0 addr=00000000",
                     inst_sram_req, inst_sram_addr);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            inst_sram_addr_ok = 1'b1;
            exp_q.push_back({1'b0, 1'b0, 32'h1C000000 + 32'(i * 4)});
            sample();
            checks++;
            if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C000000 + 32'(i * 4)) begin
                errors++;
                $display("FAIL midreset_restart[%0d]: got req=%b addr=%h, expected req=1 addr=%h",
                         i, inst_sram_req, inst_sram_addr, 32'h1C000000 + 32'(i * 4));
            end
        end
        cyc();
        inst_sram_addr_ok = 1'b0;
        sample();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d pending hand-offs, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall_redirect();
        test_priority();
        test_misaligned();
        test_allowin_low();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
